// File: rtl/md_pkg.sv
// Shared types and opcode constants for the E-stage multiply/divide sequencer.
package md_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// E-stage request, core handshake and HI/LO result bundle for muldiv_ctrl.
interface muldiv_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                  op_validE;
    logic [1:0]            opE;
    logic [DATA_W-1:0]     srcaE;
    logic [DATA_W-1:0]     srcbE;
    logic                  flushE;
    logic                  stall_pipe;
    logic [2*DATA_W-1:0]   mul_result_i;
    logic                  div_ready_i;
    logic [2*DATA_W-1:0]   div_result_i;

    logic [DATA_W-1:0]     opa_o;
    logic [DATA_W-1:0]     opb_o;
    logic                  mul_signed_o;
    logic                  div_signed_o;
    logic                  div_start_o;
    logic                  div_annul_o;
    logic                  md_stallE;
    logic                  md_valid_o;
    logic [2*DATA_W-1:0]   md_result_o;

    modport master (
        output op_validE, opE, srcaE, srcbE, flushE, stall_pipe,
               mul_result_i, div_ready_i, div_result_i,
        input  opa_o, opb_o, mul_signed_o, div_signed_o, div_start_o,
               div_annul_o, md_stallE, md_valid_o, md_result_o
    );

    modport slave (
        input  op_validE, opE, srcaE, srcbE, flushE, stall_pipe,
               mul_result_i, div_ready_i, div_result_i,
        output opa_o, opb_o, mul_signed_o, div_signed_o, div_start_o,
               div_annul_o, md_stallE, md_valid_o, md_result_o
    );

endinterface

// File: rtl/muldiv_ctrl.sv
// Sequences the multi-cycle multiplier and divider for the E stage, holding
// the pipeline until the {hi,lo} result is ready for the HI/LO write path.
module muldiv_ctrl
    import md_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MULT_LAT = 2
) (
    input  logic          clk,
    input  logic          resetn,
    muldiv_ctrl_if.slave  bus
);

    localparam int               CNT_W    = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_LAT - 1);

    md_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_opa;
    logic [DATA_W-1:0]     r_opb;
    logic                  r_mul_signed;
    logic                  r_div_signed;
    logic                  r_div_start;
    logic                  r_valid;
    logic [2*DATA_W-1:0]   r_result;

    logic                  w_accept;

    // A flushed instruction in IDLE is never accepted and never stalls E.
    assign w_accept        = (r_state == IDLE) && bus.op_validE && !bus.flushE;
    assign bus.md_stallE   = w_accept || (r_state == MUL) || (r_state == DIV);
    assign bus.div_annul_o = (r_state == DIV) && bus.flushE;

    assign bus.opa_o        = r_opa;
    assign bus.opb_o        = r_opb;
    assign bus.mul_signed_o = r_mul_signed;
    assign bus.div_signed_o = r_div_signed;
    assign bus.div_start_o  = r_div_start;
    assign bus.md_valid_o   = r_valid;
    assign bus.md_result_o  = r_result;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_mul_signed <= 1'b0;
            r_div_signed <= 1'b0;
            r_div_start  <= 1'b0;
            r_valid      <= 1'b0;
            r_result     <= '0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opa        <= bus.srcaE;
                        r_opb        <= bus.srcbE;
                        r_mul_signed <= (bus.opE == MD_MULT);
                        r_div_signed <= (bus.opE == MD_DIV);
                        if (md_is_div(bus.opE)) begin
                            r_state     <= DIV;
                            r_div_start <= 1'b1;
                        end else begin
                            r_state <= MUL;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                MUL: begin
                    if (bus.flushE) begin
                        r_state <= IDLE;
                    end else if (r_cnt == '0) begin
                        r_result <= bus.mul_result_i;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DIV: begin
                    // Flush outranks a same-cycle ready so the result is dropped.
                    if (bus.flushE) begin
                        r_state <= IDLE;
                    end else if (bus.div_ready_i) begin
                        r_result <= bus.div_result_i;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.flushE || !bus.stall_pipe) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
Name:
muldiv_ctrl

Overview:
- Sequences the multi-cycle multiplier and divider cores on behalf of the E stage.
- Latches operands when a mult/div instruction is in E, drives the core handshakes, and holds E through md_stallE.
- md_stallE feeds the hazard unit's div_stallE input.
- Hands the 64-bit {hi,lo} result to the HI/LO write path and cancels in-flight work on exception flush.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W.
MULT_LAT, 2, multiplier core latency in cycles from stable operands (legal range ≥1).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
op_validE  in  1  valid mult/div instruction in E
opE  in  2  00 mult, 01 multu, 10 div, 11 divu
srcaE  in  DATA_W  rs operand (forwarded)
srcbE  in  DATA_W  rt operand (forwarded)
flushE  in  1  exception flush of E
stall_pipe  in  1  E cannot advance (d_stall)
mul_result_i  in  2*DATA_W  multiplier core product
div_ready_i  in  1  divider done, one-cycle pulse
div_result_i  in  2*DATA_W  {remainder, quotient}
opa_o  out  DATA_W  latched operand A to both cores
opb_o  out  DATA_W  latched operand B to both cores
mul_signed_o  out  1  signed multiply
div_signed_o  out  1  signed divide
div_start_o  out  1  divider start pulse
div_annul_o  out  1  abort divider
md_stallE  out  1  hold F/D/E (to hazard div_stallE)
md_valid_o  out  1  result valid for HI/LO write
md_result_o  out  2*DATA_W  {hi, lo}

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE; all outputs 0; counter 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, op_validE=1 and flushE=0:
  - Latch srcaE, srcbE, opE.
  - Signed flags = (opE==00) for mult, (opE==10) for div.
  - Mult goes to MUL with cnt=MULT_LAT-1; div goes to DIV.
- IDLE, op_validE=1 with flushE=1: ignored; no stall.
- MUL: cnt decrements each cycle. At cnt==0, capture mul_result_i into md_result_o and go to DONE.
- DIV:
  - div_start_o=1 on the first DIV cycle only.
  - opa_o/opb_o are stable for the whole of DIV.
  - div_ready_i: capture div_result_i and go to DONE.
- DONE:
  - md_valid_o=1 and md_result_o is held.
  - stall_pipe=0: back to IDLE (the instruction advances to M).
  - stall_pipe=1: stay in DONE; no restart even though op_validE is still high.
- md_stallE = (IDLE & op_validE & ~flushE) | MUL | DIV. It is combinational and 0 in DONE.
- Stall length: mult MULT_LAT+1 cycles; div 1 + (cycles until div_ready_i).
- Flush (flushE=1) in MUL or DIV:
  - Next state IDLE; the result is discarded and md_valid_o never rises.
  - div_annul_o=1 for that one cycle if in DIV.
  - flushE wins over a simultaneous div_ready_i.
- Flush in DONE: go to IDLE; md_valid_o drops next cycle.
- stall_pipe in MUL/DIV: no effect; computation continues.
- Divide by zero: no special handling; the core's result is passed through unchanged.
- Back-to-back ops: a new op can be accepted only from IDLE, i.e. at least one cycle after leaving DONE.

Decomposition:
- Package md_pkg holds the state enum (IDLE/MUL/DIV/DONE) and opcode constants MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
- No sub-module; the latency counter is inline.

Test Plan:
- multu 0xFFFFFFFF×0x00000002, MULT_LAT=2 -> md_stallE high 3 cycles; DONE md_result_o=0x00000001_FFFFFFFE; mul_signed_o=0.
- div -7/2, core model raises div_ready_i 33 cycles after start -> div_start_o exactly 1 cycle; div_signed_o=1; result hi=0xFFFFFFFF, lo=0xFFFFFFFD; stall drops in DONE.
- div in progress, flushE at DIV cycle 10 -> div_annul_o 1 cycle; IDLE next cycle; md_valid_o never 1; md_stallE 0 after flush.
- DONE with stall_pipe held 4 cycles -> md_valid_o and result held 4 cycles; no second div_start_o; IDLE after stall_pipe falls.
- resetn low mid-MUL -> all outputs 0 immediately (asynchronous); state IDLE; a later mult proceeds normally.
- div_ready_i and flushE in the same cycle -> result discarded; md_valid_o stays 0.
